mult_div_unit: RTL and testbench



---
 rtl/mult_div_unit.sv | 218 +++++++++++++++++++++
 tb/tb_mult_div_unit.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : mult_div_unit
//  Description : Iterative HI/LO multiply/divide unit. Executes MULT/MULTU/
//                DIV/DIVU one bit per cycle (shift-add multiply, restoring
//                divide), holds HI/LO and services MTHI/MTLO writes.
//                Optional macro MDU_SIGNED_EN enables signed MULT/DIV; when
//                undefined, op[0] is ignored and every op runs unsigned.
//  Revision    : 1.0 - initial release
// ============================================================================
module mult_div_unit #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_i,
   input  logic [1:0]       op_i,
   input  logic [WIDTH-1:0] rs_data_i,
   input  logic [WIDTH-1:0] rt_data_i,
   input  logic             mthi_i,
   input  logic             mtlo_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] hi_o,
   output logic [WIDTH-1:0] lo_o
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_FIX  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

   state_t             state_q, state_d;
   logic               is_div_q, is_div_d;
   logic               div0_q, div0_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]   b_q, b_d;        // multiplicand or divisor magnitude
   logic [2*WIDTH-1:0] acc_q, acc_d;    // product, or quotient in low word
   logic [WIDTH:0]     rem_q, rem_d;    // partial remainder
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;

   // Operand magnitudes presented at the start edge
   logic [WIDTH-1:0]   mag_a, mag_b;
   logic               unused_bits;

`ifdef MDU_SIGNED_EN
   logic               neg_res_q, neg_res_d;   // operand signs differ
   logic               neg_rem_q, neg_rem_d;   // dividend was negative
   logic               signed_op, a_neg, b_neg;

   // Signed ops (op[0]=0) work on magnitudes and fix the sign at the end
   always_comb begin
      signed_op = ~op_i[0];
      a_neg     = signed_op & rs_data_i[WIDTH-1];
      b_neg     = signed_op & rt_data_i[WIDTH-1];
      mag_a     = a_neg ? (~rs_data_i + 1'b1) : rs_data_i;
      mag_b     = b_neg ? (~rt_data_i + 1'b1) : rt_data_i;
   end

   assign unused_bits = rem_q[WIDTH];
`else
   // Everything runs unsigned; op[0] carries no meaning here
   always_comb begin
      mag_a = rs_data_i;
      mag_b = rt_data_i;
   end

   assign unused_bits = ^{rem_q[WIDTH], op_i[0]};
`endif

   // One shift-add multiply step and one restoring divide step
   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] mul_next;
   logic [WIDTH:0]     rem_sh;
   logic [WIDTH+1:0]   div_diff;
   logic               div_ok;
   logic [WIDTH:0]     rem_next;
   logic [WIDTH-1:0]   quo_next;

   // Datapath for a single iteration of either operation
   always_comb begin
      mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
                 (acc_q[0] ? {1'b0, b_q} : {(WIDTH+1){1'b0}});
      mul_next = {mul_sum, acc_q[WIDTH-1:1]};
      rem_sh   = {rem_q[WIDTH-1:0], acc_q[WIDTH-1]};
      div_diff = {1'b0, rem_sh} - {2'b00, b_q};
      div_ok   = ~div_diff[WIDTH+1];
      rem_next = div_ok ? div_diff[WIDTH:0] : rem_sh;
      quo_next = {acc_q[WIDTH-2:0], div_ok};
   end

   // Final results after sign correction
   logic [2*WIDTH-1:0] fix_prod;
   logic [WIDTH-1:0]   fix_quo, fix_rem;

   // Sign correction applied in the FIX state
   always_comb begin
      fix_prod = acc_q;
      fix_quo  = acc_q[WIDTH-1:0];
      fix_rem  = rem_q[WIDTH-1:0];
`ifdef MDU_SIGNED_EN
      if (neg_res_q) begin
         fix_prod = ~acc_q + 1'b1;
         fix_quo  = ~acc_q[WIDTH-1:0] + 1'b1;
      end
      if (neg_rem_q) begin
         fix_rem = ~rem_q[WIDTH-1:0] + 1'b1;
      end
`endif
   end

   // Next-state and datapath register update logic
   always_comb begin
      state_d  = state_q;
      is_div_d = is_div_q;
      div0_d   = div0_q;
      cnt_d    = cnt_q;
      b_d      = b_q;
      acc_d    = acc_q;
      rem_d    = rem_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
`ifdef MDU_SIGNED_EN
      neg_res_d = neg_res_q;
      neg_rem_d = neg_rem_q;
`endif
      case (state_q)
         S_IDLE, S_DONE: begin
            state_d = S_IDLE;
            if (start_i) begin
               // start wins over mthi/mtlo in the same cycle
               is_div_d = op_i[1];
               div0_d   = (rt_data_i == '0);
               cnt_d    = '0;
               b_d      = mag_b;
               acc_d    = {{WIDTH{1'b0}}, mag_a};
               rem_d    = '0;
`ifdef MDU_SIGNED_EN
               neg_res_d = a_neg ^ b_neg;
               neg_rem_d = a_neg;
`endif
               state_d  = S_CALC;
            end else begin
               if (mthi_i) hi_d = rs_data_i;
               if (mtlo_i) lo_d = rs_data_i;
            end
         end
         S_CALC: begin
            cnt_d = cnt_q + 1'b1;
            if (is_div_q) begin
               acc_d = {acc_q[2*WIDTH-1:WIDTH], quo_next};
               rem_d = rem_next;
            end else begin
               acc_d = mul_next;
            end
            if (cnt_q == LAST_ITER) state_d = S_FIX;
         end
         S_FIX: begin
            if (is_div_q) begin
               // Divide by zero: remainder path already yields the dividend
               lo_d = div0_q ? {WIDTH{1'b1}} : fix_quo;
               hi_d = fix_rem;
            end else begin
               hi_d = fix_prod[2*WIDTH-1:WIDTH];
               lo_d = fix_prod[WIDTH-1:0];
            end
            state_d = S_DONE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers, cleared asynchronously
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         is_div_q <= 1'b0;
         div0_q   <= 1'b0;
         cnt_q    <= '0;
         b_q      <= '0;
         acc_q    <= '0;
         rem_q    <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
`ifdef MDU_SIGNED_EN
         neg_res_q <= 1'b0;
         neg_rem_q <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         is_div_q <= is_div_d;
         div0_q   <= div0_d;
         cnt_q    <= cnt_d;
         b_q      <= b_d;
         acc_q    <= acc_d;
         rem_q    <= rem_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
`ifdef MDU_SIGNED_EN
         neg_res_q <= neg_res_d;
         neg_rem_q <= neg_rem_d;
`endif
      end
   end

   assign busy_o = (state_q == S_CALC) || (state_q == S_FIX);
   assign done_o = (state_q == S_DONE);
   assign hi_o   = hi_q;
   assign lo_o   = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_mult_div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mult_div_unit
//  Description : Directed-vector bench for mult_div_unit. Expected values for
//                signed ops depend on MDU_SIGNED_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mult_div_unit;

   localparam int W = 32;
   localparam logic [1:0] OP_MULT = 2'b00, OP_MULTU = 2'b01,
                          OP_DIV  = 2'b10, OP_DIVU  = 2'b11;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic [1:0]    op = 2'b00;
   logic [W-1:0]  rs = '0, rt = '0;
   logic          mthi = 1'b0, mtlo = 1'b0;
   logic          busy, done;
   logic [W-1:0]  hi, lo;

   int n_cmp  = 0;
   int n_fail = 0;

   mult_div_unit #(.WIDTH(W), .CNT_W(6)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start_i   (start),
      .op_i      (op),
      .rs_data_i (rs),
      .rt_data_i (rt),
      .mthi_i    (mthi),
      .mtlo_i    (mtlo),
      .busy_o    (busy),
      .done_o    (done),
      .hi_o      (hi),
      .lo_o      (lo)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]   op;
      logic [W-1:0] rs;
      logic [W-1:0] rt;
      logic [W-1:0] hi;
      logic [W-1:0] lo;
   } vec_t;

   vec_t vecs[10];

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Called just after a negedge. Pulses start across the next posedge (E0),
   // scrambles operands afterwards, and returns at the negedge where done=1.
   task automatic run_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         output int edges, output int busy_cnt);
      start = 1'b1; op = o; rs = a; rt = b;
      edges = 0; busy_cnt = 0;
      do begin
         @(negedge clk);
         edges++;
         if (edges == 1) begin
            start = 1'b0; rs = ~a; rt = a ^ 32'h5A5A_0F0F;
         end
         if (busy) busy_cnt++;
      end while (!done && edges < 200);
   endtask

   function automatic vec_t mk(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic [W-1:0] h, input logic [W-1:0] l);
      vec_t v;
      v.op = o; v.rs = a; v.rt = b; v.hi = h; v.lo = l;
      return v;
   endfunction

   initial begin
      int edges, bcnt;
      logic [W-1:0] hold;

      vecs[0] = mk(OP_MULTU, 32'd7,          32'd6,          32'h0,          32'd42);
      vecs[1] = mk(OP_MULTU, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE,  32'h0000_0001);
      vecs[2] = mk(OP_DIVU,  32'd100,        32'd7,          32'd2,          32'd14);
      vecs[3] = mk(OP_DIVU,  32'd9,          32'd0,          32'd9,          32'hFFFF_FFFF);
      vecs[4] = mk(OP_DIV,   32'hFFFF_FFF7,  32'd0,          32'hFFFF_FFF7,  32'hFFFF_FFFF);
      vecs[5] = mk(OP_DIVU,  32'hFFFF_FFFF,  32'd1,          32'h0,          32'hFFFF_FFFF);
`ifdef MDU_SIGNED_EN
      vecs[6] = mk(OP_MULT,  32'hFFFF_FFFB,  32'd3,          32'hFFFF_FFFF,  32'hFFFF_FFF1);
      vecs[7] = mk(OP_DIV,   32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  32'hFFFF_FFFD);
      vecs[8] = mk(OP_DIV,   32'h8000_0000,  32'hFFFF_FFFF,  32'h0,          32'h8000_0000);
      vecs[9] = mk(OP_MULT,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0,          32'h0000_0001);
`else
      vecs[6] = mk(OP_MULT,  32'hFFFF_FFFB,  32'd3,          32'h0000_0002,  32'hFFFF_FFF1);
      vecs[7] = mk(OP_DIV,   32'hFFFF_FFF9,  32'd2,          32'h0000_0001,  32'h7FFF_FFFC);
      vecs[8] = mk(OP_DIV,   32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'h0);
      vecs[9] = mk(OP_MULT,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE,  32'h0000_0001);
`endif

      // Reset state
      #12;
      chk("reset_busy", {31'b0, busy}, 32'd0);
      chk("reset_done", {31'b0, done}, 32'd0);
      chk("reset_hi", hi, 32'd0);
      chk("reset_lo", lo, 32'd0);
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk);

      // Table-driven operations
      for (int i = 0; i < 10; i++) begin
         run_op(vecs[i].op, vecs[i].rs, vecs[i].rt, edges, bcnt);
         chk($sformatf("v%0d_latency", i), edges, 34);
         chk($sformatf("v%0d_busy_cycles", i), bcnt, 33);
         chk($sformatf("v%0d_hi", i), hi, vecs[i].hi);
         chk($sformatf("v%0d_lo", i), lo, vecs[i].lo);
         @(negedge clk);
         chk($sformatf("v%0d_done_drop", i), {31'b0, done}, 32'd0);
      end

      // MTHI while idle, then MTHI+MTLO together
      mthi = 1'b1; rs = 32'h1234;
      @(negedge clk); mthi = 1'b0;
      chk("mthi_hi", hi, 32'h1234);
      chk("mthi_lo_kept", lo, vecs[9].lo);
      mthi = 1'b1; mtlo = 1'b1; rs = 32'hABCD_0001;
      @(negedge clk); mthi = 1'b0; mtlo = 1'b0;
      chk("mthilo_hi", hi, 32'hABCD_0001);
      chk("mthilo_lo", lo, 32'hABCD_0001);

      // start has priority over a simultaneous mthi
      start = 1'b1; mthi = 1'b1; op = OP_MULTU; rs = 32'd7; rt = 32'd6;
      @(negedge clk); start = 1'b0; mthi = 1'b0;
      chk("start_prio_hi", hi, 32'hABCD_0001);
      chk("start_prio_busy", {31'b0, busy}, 32'd1);
      // mtlo and a second start while busy are ignored
      repeat (5) @(negedge clk);
      mtlo = 1'b1; rs = 32'hDEAD_BEEF;
      @(negedge clk); mtlo = 1'b0;
      start = 1'b1; op = OP_DIVU; rs = 32'd50; rt = 32'd3;
      @(negedge clk); start = 1'b0;
      chk("busy_mtlo_ignored", lo, 32'hABCD_0001);
      edges = 0;
      while (!done && edges < 100) begin @(negedge clk); edges++; end
      chk("busy_done_seen", {31'b0, done}, 32'd1);
      chk("busy_ignore_hi", hi, 32'd0);
      chk("busy_ignore_lo", lo, 32'd42);

      // start accepted in the DONE cycle
      run_op(OP_DIVU, 32'd100, 32'd7, edges, bcnt);
      chk("done_start_latency", edges, 34);
      chk("done_start_lo", lo, 32'd14);
      chk("done_start_hi", hi, 32'd2);
      @(negedge clk);
      chk("done_start_no_repeat", {31'b0, busy}, 32'd0);

      // Asynchronous reset mid-operation
      start = 1'b1; op = OP_MULTU; rs = 32'd3; rt = 32'd3;
      @(negedge clk); start = 1'b0;
      repeat (9) @(negedge clk);
      hold = hi;
      chk("pre_reset_busy", {31'b0, busy}, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("async_busy", {31'b0, busy}, 32'd0);
      chk("async_done", {31'b0, done}, 32'd0);
      chk("async_hi", hi, 32'd0);
      chk("async_lo", lo, 32'd0);
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk);
      chk("post_reset_idle", {31'b0, busy}, 32'd0);
      run_op(OP_MULTU, 32'd3, 32'd3, edges, bcnt);
      chk("post_reset_latency", edges, 34);
      chk("post_reset_busy_cycles", bcnt, 33);
      chk("post_reset_hi", hi, 32'd0);
      chk("post_reset_lo", lo, 32'd9);
      if (hold !== 32'd2) begin
         n_cmp++;
         n_fail++;
         $display("FAIL pre_reset_hi: got %h expected %h", hold, 32'd2);
      end else begin
         n_cmp++;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
